ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Downstream of the PS/2 keyboard frame receiver.
- Consumes raw Set-2 scan-code bytes already synchronised into the Clock domain.
- Resolves E0/F0/E1 prefixes, tracks Shift and Caps-Lock state, translates make/break codes to ASCII, and buffers key events in a small FIFO behind a valid/ready handshake.
- Feeds the display/console logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- iScanCode  in  8  scan-code byte from the receiver.
- iScanValid  in  1  one-cycle strobe; iScanCode is valid while this is high.
- iReady  in  1  consumer accepts the head event this cycle.
- oValid  out  1  FIFO non-empty; the head event is presented.
- oScanCode  out  8  head event: final (non-prefix) scan code.
- oAscii  out  8  head event: ASCII translation, 0x00 if unmapped.
- oBreak  out  1  head event: key released.
- oExtended  out  1  head event: E0-prefixed.
- oShift  out  1  live state: either Shift held.
- oCaps  out  1  live state: Caps-Lock toggle.
- oOverflow  out  1  sticky flag: an event was dropped.
- oCount  out  AW+1  FIFO occupancy.

Behaviour:
- Reset:
  - Reset is asynchronous, active-high; Clock is the system clock.
  - On reset, all outputs are 0, the FSM is in IDLE, the FIFO is empty, and all modifier state is cleared.
  - Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen). Transitions occur only on iScanValid.
  - IDLE:
    - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter = 7.
    - AA, FA, EE, FE, 00, FF -> ignored, stay IDLE.
    - Any other byte -> make event, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> extended make event -> IDLE.
  - BRK: F0 -> stay BRK; other -> break event -> IDLE.
  - EXT_BRK: any byte -> extended break event -> IDLE.
  - PAUSE: decrement the counter on each byte; return to IDLE when it reaches 0. No events are generated.
- Modifiers (non-extended codes only; never pushed to the FIFO):
  - 12 (left Shift) and 59 (right Shift) set or clear their held bit on make/break. oShift is the OR of both held bits.
  - 58 toggles oCaps on make only when the caps-held bit is 0. The caps-held bit is set on make and cleared on break, so typematic repeats do not re-toggle.
- ASCII map (non-extended):
  - Letters: 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F, 34=G, 33=H, 43=I, 3B=J, 42=K, 4B=L, 3A=M, 31=N, 44=O, 4D=P, 15=Q, 2D=R, 1B=S, 2C=T, 3C=U, 2A=V, 1D=W, 22=X, 35=Y, 1A=Z. Uppercase when oShift XOR oCaps, else lowercase.
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9. Unaffected by Shift or Caps.
  - Controls: 29=0x20, 5A=0x0D, 66=0x08, 76=0x1B.
  - Everything else, and all extended codes, map to 0x00.
  - Break events carry the same ASCII a make would, using modifier state at decode time.
- Latency: the event is decoded and written on the edge that samples the final byte. oValid rises on the next edge, so latency is 2 edges from the sampling edge to oValid.
- FIFO: show-ahead; the head is always on the outputs when oValid=1.
  - Pop: oValid & iReady.
  - Push and pop in the same cycle: both happen, including when full; oCount is unchanged.
  - Push while full without a pop: event dropped, oOverflow set until Reset, FIFO contents untouched.
  - Pop while empty: no effect.
  - Pointers wrap modulo DEPTH.
  - oCount ranges 0..DEPTH.

Optional Feature:
- Macro: PS2_DECODER_REPEAT_FILTER_EN.
- Defined:
  - A register holds the last pushed make code plus its extended bit.
  - A make event identical to it is discarded (typematic repeat suppression; oOverflow is unaffected).
  - A break of that key clears the register.
  - Any different make overwrites it.
- Undefined: every typematic make is pushed.

Test Plan:
- Bytes 1C, F0 1C with iReady=1 -> two events: (1C, 'a'=0x61, brk 0) then (1C, 0x61, brk 1). oValid rises 2 edges after the 1C strobe.
- Bytes 12, 1C, F0 12, 58, F0 58, 1C -> 'A'=0x41 (shift), then 'A'=0x41 (caps). oCaps=1 and oShift=0 at end; no events for 12 or 58.
- Bytes E0 75, E0 F0 75 -> (75, 0x00, ext 1, brk 0) then (75, 0x00, ext 1, brk 1).
- iReady=0 and DEPTH+1 make codes 16 -> oCount=4 and oOverflow=1. Raising iReady drains 4 events of '1'=0x31; oOverflow stays 1.
- Bytes E1 14 77 E1 F0 14 F0 77, then 29 -> only a space event (0x20). Reset asserted after a lone F0 -> next 1C yields a make event.
- With PS2_DECODER_REPEAT_FILTER_EN defined, bytes 1C 1C 1C F0 1C 1C -> events: make, break, make. Without the macro -> 4 makes and 1 break.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// ps2_scancode_decoder: Set-2 scan-code bytes -> key events with ASCII, in a FIFO.
// Optional macro PS2_DECODER_REPEAT_FILTER_EN suppresses typematic repeat makes.
// Revision 1.0
// ============================================================================
module ps2_scancode_decoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [7:0]    iScanCode,
    input  logic          iScanValid,
    input  logic          iReady,
    output logic          oValid,
    output logic [7:0]    oScanCode,
    output logic [7:0]    oAscii,
    output logic          oBreak,
    output logic          oExtended,
    output logic          oShift,
    output logic          oCaps,
    output logic          oOverflow,
    output logic [AW:0]   oCount
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t     state;
    logic [2:0] skip_cnt;
    logic       shift_l, shift_r, caps, caps_held;

    logic       ev_fire, ev_ext, ev_brk, is_mod, repeat_hit;

    logic       pend_valid, pend_brk, pend_ext;
    logic [7:0] pend_code, pend_ascii;

    logic [7:0]    mem_code  [DEPTH];
    logic [7:0]    mem_ascii [DEPTH];
    logic          mem_brk   [DEPTH];
    logic          mem_ext   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow, full, pop, push_ok;

    function automatic logic [7:0] map_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] lc;
        logic       letter;
        letter = 1'b1;
        unique case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            default: begin
                letter = 1'b0;
                unique case (code)
                    8'h45: lc = "0";  8'h16: lc = "1";  8'h1E: lc = "2";  8'h26: lc = "3";
                    8'h25: lc = "4";  8'h2E: lc = "5";  8'h36: lc = "6";  8'h3D: lc = "7";
                    8'h3E: lc = "8";  8'h46: lc = "9";
                    8'h29: lc = 8'h20;  8'h5A: lc = 8'h0D;
                    8'h66: lc = 8'h08;  8'h76: lc = 8'h1B;
                    default: lc = 8'h00;
                endcase
            end
        endcase
        return (letter && upper) ? (lc - 8'h20) : lc;
    endfunction

    // Which bytes complete an event, given the prefix state
    always_comb begin
        ev_fire = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (iScanValid) begin
            unique case (state)
                IDLE: begin
                    unique case (iScanCode)
                        8'hE0, 8'hF0, 8'hE1,
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ev_fire = 1'b0;
                        default: ev_fire = 1'b1;
                    endcase
                end
                EXT: begin
                    ev_fire = (iScanCode != 8'hF0) && (iScanCode != 8'hE0);
                    ev_ext  = 1'b1;
                end
                BRK: begin
                    ev_fire = (iScanCode != 8'hF0);
                    ev_brk  = 1'b1;
                end
                EXT_BRK: begin
                    ev_fire = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                end
                default: ev_fire = 1'b0;
            endcase
        end
    end

    assign is_mod = !ev_ext && ((iScanCode == 8'h12) || (iScanCode == 8'h59) ||
                                (iScanCode == 8'h58));

`ifdef PS2_DECODER_REPEAT_FILTER_EN
    logic [7:0] last_code;
    logic       last_ext, last_vld;
    logic       same_key;

    assign same_key   = last_vld && (last_code == iScanCode) && (last_ext == ev_ext);
    assign repeat_hit = same_key && !ev_brk;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_code <= 8'h00;
            last_ext  <= 1'b0;
            last_vld  <= 1'b0;
        end else if (ev_fire && !is_mod) begin
            if (ev_brk) begin
                if (same_key) last_vld <= 1'b0;
            end else begin
                last_code <= iScanCode;
                last_ext  <= ev_ext;
                last_vld  <= 1'b1;
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    // Prefix FSM, modifier tracking and the decoded-event register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            skip_cnt   <= 3'd0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            caps       <= 1'b0;
            caps_held  <= 1'b0;
            pend_valid <= 1'b0;
            pend_code  <= 8'h00;
            pend_ascii <= 8'h00;
            pend_brk   <= 1'b0;
            pend_ext   <= 1'b0;
        end else begin
            pend_valid <= ev_fire && !is_mod && !repeat_hit;
            if (iScanValid) begin
                unique case (state)
                    IDLE: begin
                        if (iScanCode == 8'hE0) state <= EXT;
                        else if (iScanCode == 8'hF0) state <= BRK;
                        else if (iScanCode == 8'hE1) begin
                            state    <= PAUSE;
                            skip_cnt <= 3'd7;
                        end
                    end
                    EXT:     if (iScanCode == 8'hF0) state <= EXT_BRK;
                             else if (iScanCode != 8'hE0) state <= IDLE;
                    BRK:     if (iScanCode != 8'hF0) state <= IDLE;
                    EXT_BRK: state <= IDLE;
                    default: begin
                        skip_cnt <= skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) state <= IDLE;
                    end
                endcase
            end
            if (ev_fire) begin
                pend_code  <= iScanCode;
                pend_brk   <= ev_brk;
                pend_ext   <= ev_ext;
                pend_ascii <= ev_ext ? 8'h00 : map_ascii(iScanCode, (shift_l | shift_r) ^ caps);
                if (is_mod) begin
                    if (iScanCode == 8'h12) shift_l <= !ev_brk;
                    else if (iScanCode == 8'h59) shift_r <= !ev_brk;
                    else if (ev_brk) caps_held <= 1'b0;
                    else begin
                        if (!caps_held) caps <= ~caps;
                        caps_held <= 1'b1;
                    end
                end
            end
        end
    end

    assign full    = (count == FULL_COUNT);
    assign pop     = (count != '0) && iReady;
    assign push_ok = pend_valid && (!full || pop);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_code[i]  <= 8'h00;
                mem_ascii[i] <= 8'h00;
                mem_brk[i]   <= 1'b0;
                mem_ext[i]   <= 1'b0;
            end
        end else begin
            if (push_ok) begin
                mem_code[wr_ptr]  <= pend_code;
                mem_ascii[wr_ptr] <= pend_ascii;
                mem_brk[wr_ptr]   <= pend_brk;
                mem_ext[wr_ptr]   <= pend_ext;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop) count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (pend_valid && full && !pop) overflow <= 1'b1;
        end
    end

    assign oValid    = (count != '0);
    assign oScanCode = mem_code[rd_ptr];
    assign oAscii    = mem_ascii[rd_ptr];
    assign oBreak    = mem_brk[rd_ptr];
    assign oExtended = mem_ext[rd_ptr];
    assign oShift    = shift_l | shift_r;
    assign oCaps     = caps;
    assign oOverflow = overflow;
    assign oCount    = count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// Scoreboard bench for ps2_scancode_decoder: directed byte sequences, queued expectations.
module tb_ps2_scancode_decoder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iScanCode = 8'h00;
    logic       iScanValid = 1'b0;
    logic       iReady = 1'b1;
    logic       oValid, oBreak, oExtended, oShift, oCaps, oOverflow;
    logic [7:0] oScanCode, oAscii;
    logic [2:0] oCount;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] ascii;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    ps2_scancode_decoder #(.DEPTH(4), .AW(2)) dut (
        .Clock(Clock), .Reset(Reset), .iScanCode(iScanCode), .iScanValid(iScanValid),
        .iReady(iReady), .oValid(oValid), .oScanCode(oScanCode), .oAscii(oAscii),
        .oBreak(oBreak), .oExtended(oExtended), .oShift(oShift), .oCaps(oCaps),
        .oOverflow(oOverflow), .oCount(oCount)
    );

    always #5 Clock = ~Clock;

    // Monitor: every accepted head event must match the oldest expectation
    always @(negedge Clock) begin
        if (!Reset && oValid && iReady) begin
            ev_t got;
            got = '{oScanCode, oAscii, oBreak, oExtended};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got code=%h ascii=%h brk=%b ext=%b",
                         oScanCode, oAscii, oBreak, oExtended);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL event got code=%h ascii=%h brk=%b ext=%b expected code=%h ascii=%h brk=%b ext=%b",
                             oScanCode, oAscii, oBreak, oExtended, e.code, e.ascii, e.brk, e.ext);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic [7:0] ascii,
                             input logic brk, input logic ext);
        exp_q.push_back('{code, ascii, brk, ext});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge Clock); #1;
        iScanCode  = b;
        iScanValid = 1'b1;
        @(posedge Clock); #1;
        iScanValid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !oValid) begin
                done = 1;
                break;
            end
            @(posedge Clock); #1;
        end
        check({name, "_drain"}, {31'd0, done}, 32'd1);
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_valid"}, {31'd0, oValid}, 32'd0);
        check({name, "_count"}, {29'd0, oCount}, 32'd0);
        check({name, "_ovf"},   {31'd0, oOverflow}, 32'd0);
        check({name, "_mods"},  {30'd0, oShift, oCaps}, 32'd0);
        check({name, "_head"},  {14'd0, oScanCode, oAscii, oBreak, oExtended}, 32'd0);
    endtask

    initial begin
        #2;
        check_reset_state("reset_hold");
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;

        // Make and break of 'a', with latency check on the make
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        expect_ev(8'h1C, 8'h61, 1'b1, 1'b0);
        send(8'h1C);
        check("latency_edge1", {31'd0, oValid}, 32'd0);
        @(posedge Clock); #1;
        check("latency_edge2", {31'd0, oValid}, 32'd1);
        send(8'hF0); send(8'h1C);
        wait_empty("t1");

        // Shift then Caps both uppercase; modifiers generate no events
        expect_ev(8'h1C, 8'h41, 1'b0, 1'b0);
`ifndef PS2_DECODER_REPEAT_FILTER_EN
        expect_ev(8'h1C, 8'h41, 1'b0, 1'b0);
`endif
        send(8'h12);
        send(8'h1C);
        check("shift_held", {31'd0, oShift}, 32'd1);
        send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        send(8'h1C);
        wait_empty("t2");
        check("caps_on", {31'd0, oCaps}, 32'd1);
        check("shift_off", {31'd0, oShift}, 32'd0);

        // Extended make/break
        expect_ev(8'h75, 8'h00, 1'b0, 1'b1);
        expect_ev(8'h75, 8'h00, 1'b1, 1'b1);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        wait_empty("t3");

        // Overflow: five makes into a four-entry FIFO with the consumer stalled
        iReady = 1'b0;
`ifdef PS2_DECODER_REPEAT_FILTER_EN
        expect_ev(8'h16, 8'h31, 1'b0, 1'b0);
        expect_ev(8'h1E, 8'h32, 1'b0, 1'b0);
        expect_ev(8'h16, 8'h31, 1'b0, 1'b0);
        expect_ev(8'h1E, 8'h32, 1'b0, 1'b0);
        send(8'h16); send(8'h1E); send(8'h16); send(8'h1E); send(8'h16);
`else
        for (int i = 0; i < 4; i++) expect_ev(8'h16, 8'h31, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(8'h16);
`endif
        repeat (2) @(posedge Clock);
        #1;
        check("full_count", {29'd0, oCount}, 32'd4);
        check("overflow_set", {31'd0, oOverflow}, 32'd1);
        check("full_valid", {31'd0, oValid}, 32'd1);
        iReady = 1'b1;
        wait_empty("t4");
        check("overflow_sticky", {31'd0, oOverflow}, 32'd1);
        check("drained_count", {29'd0, oCount}, 32'd0);

        // Pause sequence swallowed, then a space
        expect_ev(8'h29, 8'h20, 1'b0, 1'b0);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h29);
        wait_empty("t5");

        // Reset after a lone F0 discards the break prefix
        send(8'hF0);
        @(posedge Clock); #1 Reset = 1'b1;
        #2;
        check_reset_state("reset_mid");
        @(posedge Clock); #1 Reset = 1'b0;
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        expect_ev(8'h1C, 8'h61, 1'b1, 1'b0);
        send(8'h1C);
        send(8'hF0); send(8'h1C);
        wait_empty("t6");

        // Typematic repeats
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
`ifndef PS2_DECODER_REPEAT_FILTER_EN
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
`endif
        expect_ev(8'h1C, 8'h61, 1'b1, 1'b0);
        expect_ev(8'h1C, 8'h61, 1'b0, 1'b0);
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'h1C);
        wait_empty("t7");

        repeat (4) @(posedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
